enemy_path_seq: RTL and testbench

Path-address sequencer for one enemy. It steps a 12-bit trajectory index once every STEP_DIV frames and drives the `addr` input of the per-enemy trajectory ROM stage, which turns the index into x/y. It also tracks the enemy life cycle: idle, running, killed, then respawn after a fixed number of frames. One instance sits directly upstream of each enemy's coordinate ROM stage.

---
 rtl/enemy_path_if.sv | 28 ++
 rtl/enemy_path_seq.sv | 149 ++++++++++++++
 tb/tb_enemy_path_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/enemy_path_if.sv
// rtl/enemy_path_if.sv - handshake bundle between frame/collision logic and the enemy path sequencer
// Signals:
//   frame_tick  one-cycle pulse per frame (vblank start)
//   start       launches the enemy from IDLE
//   hit         one-cycle collision pulse
//   addr[11:0]  trajectory index to the ROM stage
//   alive       high while the enemy is running
//   killed      one-cycle pulse on the RUN->DEAD transition
//   dir         0 ascending, 1 descending
interface enemy_path_if;
    logic        frame_tick;
    logic        start;
    logic        hit;
    logic [11:0] addr;
    logic        alive;
    logic        killed;
    logic        dir;

    modport master (
        output frame_tick, start, hit,
        input  addr, alive, killed, dir
    );

    modport slave (
        input  frame_tick, start, hit,
        output addr, alive, killed, dir
    );
endinterface

// File: rtl/enemy_path_seq.sv
// rtl/enemy_path_seq.sv - per-enemy trajectory address sequencer with IDLE/RUN/DEAD life cycle
// Ports:
//   pclk  pixel clock, the only clock
//   rst   asynchronous active-high reset
//   bus   enemy_path_if.slave: frame_tick/start/hit in, addr/alive/killed/dir out (all registered)
// Parameters:
//   ADDR_MAX        last valid trajectory index
//   STEP_DIV        frame ticks per address step (1..255)
//   RESPAWN_FRAMES  frame ticks spent dead before restarting (1..4095)
//   PINGPONG        1 bounces 0->MAX->0, 0 wraps MAX->0
module enemy_path_seq #(
    parameter int ADDR_MAX       = 301,
    parameter int STEP_DIV       = 2,
    parameter int RESPAWN_FRAMES = 120,
    parameter bit PINGPONG       = 1'b1
) (
    input  logic          pclk,
    input  logic          rst,
    enemy_path_if.slave   bus
);

    localparam logic [11:0] ADDR_LAST = 12'(ADDR_MAX);
    localparam logic [7:0]  DIV_LAST  = 8'(STEP_DIV - 1);
    localparam logic [11:0] RESP_LAST = 12'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic        dir_q, dir_d;
    logic        alive_q, alive_d;
    logic        killed_q, killed_d;
    logic [7:0]  div_q, div_d;
    logic [11:0] resp_q, resp_d;

    // Next trajectory position from the current one; only used on a qualifying step.
    logic [11:0] step_addr;
    logic        step_dir;

    always_comb begin
        step_addr = addr_q;
        step_dir  = dir_q;
        if (PINGPONG) begin
            if (!dir_q) begin
                if (addr_q < ADDR_LAST) begin
                    step_addr = addr_q + 12'd1;
                end else begin
                    // Turn at the top without repeating the endpoint.
                    step_addr = addr_q - 12'd1;
                    step_dir  = 1'b1;
                end
            end else begin
                if (addr_q != 12'd0) begin
                    step_addr = addr_q - 12'd1;
                end else begin
                    step_addr = 12'd1;
                    step_dir  = 1'b0;
                end
            end
        end else begin
            step_addr = (addr_q == ADDR_LAST) ? 12'd0 : addr_q + 12'd1;
            step_dir  = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dir_d    = dir_q;
        div_d    = div_q;
        resp_d   = resp_q;
        killed_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                addr_d = 12'd0;
                dir_d  = 1'b0;
                div_d  = 8'd0;
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // hit takes priority over a simultaneous frame tick: no step.
                if (bus.hit) begin
                    state_d  = S_DEAD;
                    killed_d = 1'b1;
                    resp_d   = 12'd0;
                end else if (bus.frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d  = 8'd0;
                        addr_d = step_addr;
                        dir_d  = step_dir;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            S_DEAD: begin
                if (bus.frame_tick) begin
                    if (resp_q == RESP_LAST) begin
                        state_d = S_RUN;
                        addr_d  = 12'd0;
                        dir_d   = 1'b0;
                        div_d   = 8'd0;
                    end else begin
                        resp_d = resp_q + 12'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so alive rises/falls on the same edge as the state change.
        alive_d = (state_d == S_RUN);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 12'd0;
            dir_q    <= 1'b0;
            alive_q  <= 1'b0;
            killed_q <= 1'b0;
            div_q    <= 8'd0;
            resp_q   <= 12'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dir_q    <= dir_d;
            alive_q  <= alive_d;
            killed_q <= killed_d;
            div_q    <= div_d;
            resp_q   <= resp_d;
        end
    end

    assign bus.addr   = addr_q;
    assign bus.dir    = dir_q;
    assign bus.alive  = alive_q;
    assign bus.killed = killed_q;

endmodule

// File: tb/tb_enemy_path_seq.sv
// tb/tb_enemy_path_seq.sv - randomized self-checking bench for enemy_path_seq (ping-pong and wrap instances)
module tb_enemy_path_seq;

    localparam int AMAX = 301;

    logic pclk;
    logic rst;

    enemy_path_if bus_a ();
    enemy_path_if bus_b ();

    enemy_path_seq #(
        .ADDR_MAX(AMAX), .STEP_DIV(2), .RESPAWN_FRAMES(4), .PINGPONG(1'b1)
    ) dut_a (
        .pclk(pclk), .rst(rst), .bus(bus_a.slave)
    );

    enemy_path_seq #(
        .ADDR_MAX(AMAX), .STEP_DIV(1), .RESPAWN_FRAMES(7), .PINGPONG(1'b0)
    ) dut_b (
        .pclk(pclk), .rst(rst), .bus(bus_b.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic start, hit, tick;
    assign bus_a.start = start;
    assign bus_a.hit = hit;
    assign bus_a.frame_tick = tick;
    assign bus_b.start = start;
    assign bus_b.hit = hit;
    assign bus_b.frame_tick = tick;

    logic [11:0] got_addr [2];
    logic        got_dir [2];
    logic        got_alive [2];
    logic        got_killed [2];
    assign got_addr[0]   = bus_a.addr;
    assign got_dir[0]    = bus_a.dir;
    assign got_alive[0]  = bus_a.alive;
    assign got_killed[0] = bus_a.killed;
    assign got_addr[1]   = bus_b.addr;
    assign got_dir[1]    = bus_b.dir;
    assign got_alive[1]  = bus_b.alive;
    assign got_killed[1] = bus_b.killed;

    // Reference model: life-cycle phase plus tick counts; position derived arithmetically.
    int sd [2] = '{2, 1};
    int rf [2] = '{4, 7};
    int pp [2] = '{1, 0};
    int mst [2];        // 0 idle, 1 running, 2 dead
    int run_t [2];      // frame ticks seen since entering RUN
    int dead_t [2];     // frame ticks seen since the kill
    int fa [2];
    int fd [2];
    int kil [2];

    int n_cmp = 0;
    int n_err = 0;
    int max_seen = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_pos(input int i, output int a, output int d);
        int n, p;
        n = run_t[i] / sd[i];
        if (pp[i] != 0) begin
            p = n % (2 * AMAX);
            a = (p <= AMAX) ? p : 2 * AMAX - p;
            d = ((p > AMAX) || (p == 0 && n > 0)) ? 1 : 0;
        end else begin
            a = n % (AMAX + 1);
            d = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mst[i] = 0; run_t[i] = 0; dead_t[i] = 0; fa[i] = 0; fd[i] = 0; kil[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit st, input bit ht, input bit tk);
        int a, d;
        kil[i] = 0;
        case (mst[i])
            0: if (st) begin mst[i] = 1; run_t[i] = 0; end
            1: begin
                if (ht) begin
                    exp_pos(i, a, d);
                    fa[i] = a; fd[i] = d;
                    mst[i] = 2; dead_t[i] = 0; kil[i] = 1;
                end else if (tk) begin
                    run_t[i]++;
                end
            end
            default: begin
                if (tk) begin
                    dead_t[i]++;
                    if (dead_t[i] == rf[i]) begin mst[i] = 1; run_t[i] = 0; end
                end
            end
        endcase
    endtask

    task automatic compare_all(input string pfx);
        int a, d;
        for (int i = 0; i < 2; i++) begin
            if (mst[i] == 1) exp_pos(i, a, d);
            else if (mst[i] == 2) begin a = fa[i]; d = fd[i]; end
            else begin a = 0; d = 0; end
            check_eq($sformatf("%s_addr%0d", pfx, i), int'(got_addr[i]), a);
            check_eq($sformatf("%s_dir%0d", pfx, i), int'(got_dir[i]), d);
            check_eq($sformatf("%s_alive%0d", pfx, i), int'(got_alive[i]), (mst[i] == 1) ? 1 : 0);
            check_eq($sformatf("%s_killed%0d", pfx, i), int'(got_killed[i]), kil[i]);
            if (i == 0 && int'(got_addr[0]) > max_seen) max_seen = int'(got_addr[0]);
        end
    endtask

    initial begin
        int rst_hold;
        int hit_div, start_div, phase_len;
        rst = 1'b1;
        start = 1'b0; hit = 1'b0; tick = 1'b0;
        rst_hold = 0;
        model_reset();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        compare_all("reset");
        rst = 1'b0;

        for (int ph = 0; ph < 3; ph++) begin
            // phase 0: long hit-free runs reaching both endpoints; 1: frequent kills; 2: async resets
            phase_len = (ph == 0) ? 8000 : 4000;
            hit_div   = (ph == 0) ? 0 : (ph == 1) ? 12 : 200;
            start_div = (ph == 0) ? 8 : 4;
            for (int c = 0; c < phase_len; c++) begin
                @(negedge pclk);
                compare_all("cyc");
                if (rst) begin
                    rst_hold--;
                    start = 1'b0; hit = 1'b0; tick = 1'b0;
                    if (rst_hold > 0) continue;
                    rst = 1'b0;
                end else if (ph == 2 && $urandom_range(0, 299) == 0) begin
                    // Reset lands mid-period, well away from any clock edge.
                    rst = 1'b1;
                    #1;
                    model_reset();
                    compare_all("async_rst");
                    rst_hold = int'($urandom_range(1, 3));
                    start = 1'b0; hit = 1'b0; tick = 1'b0;
                    continue;
                end
                start = ($urandom_range(0, start_div - 1) == 0);
                hit   = (hit_div != 0) && ($urandom_range(0, hit_div - 1) == 0);
                tick  = $urandom_range(0, 1) == 1;
                for (int i = 0; i < 2; i++) model_step(i, start, hit, tick);
            end
        end

        @(negedge pclk);
        compare_all("final");
        n_cmp++;
        if (max_seen != AMAX) begin
            n_err++;
            $display("FAIL pingpong_peak got=%0d exp=%0d", max_seen, AMAX);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
